// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, queue entry, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   // Entry width is fixed here; the top's XLEN parameter must match it.
   localparam int FETCH_XLEN = 32;

   // addi x0, x0, 0 -- presented to ID whenever the prefetch queue is empty.
   localparam logic [FETCH_XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // ready to issue a fetch request
      S_WAIT = 2'd1,   // request accepted, response pending, queue slot reserved
      S_DROP = 2'd2    // response pending for a stale (pre-redirect) address
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO of fetched {pc, inst} pairs with synchronous clear.
// Latency: a pushed entry becomes the head the cycle after the push.
// Backpressure: push is ignored when full, pop when empty; clear beats push and pop.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/dat_i   write an entry      pop_i   retire the head      clear_i   flush all
//   head_o         oldest entry        count_o occupancy (0..DEPTH)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  T                         dat_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   output T                         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push, do_pop;

   assign do_push = push_i & ~clear_i & (count_q != FULL);
   assign do_pop  = pop_i  & ~clear_i & (count_q != '0);

   // Storage needs no reset: the top masks the head while the queue is empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= dat_i;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch: one-outstanding I-cache requester feeding a DEPTH-entry prefetch queue to ID.
// Latency: request -> response (>=1 cycle) -> head visible to ID the cycle after the push.
// Backpressure: requests stop while the queue plus the in-flight slot is full; ID drains via id_ready & ~stall.
//   redirect in : jump/jump_target (wins), branch/branch_target      stall : freezes dequeue
//   imem        : req_valid/req_addr/req_ready out, resp_valid/resp_data in
//   ID          : id_valid/id_inst/id_pc/id_pc_plus4 out, id_ready in; if_flush out on redirect
//   perf        : perf_cycles, perf_fetched (pops), perf_stalls (stall cycles)
module if_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jump,
   input  logic [XLEN-1:0]  jump_target,
   input  logic             branch,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             stall,
   output logic             imem_req_valid,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_resp_valid,
   input  logic [XLEN-1:0]  imem_resp_data,
   output logic             id_valid,
   output logic [XLEN-1:0]  id_inst,
   output logic [XLEN-1:0]  id_pc,
   output logic [XLEN-1:0]  id_pc_plus4,
   input  logic             id_ready,
   output logic             if_flush,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_fetched,
   output logic [CNT_W-1:0] perf_stalls
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] cycles_q, fetched_q, stalls_q;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            q_push, q_pop, q_empty;
   logic [CW-1:0]   q_count;
   fetch_entry_t    q_head, q_in;

   assign redirect = jump | branch;
   assign target   = jump ? jump_target : branch_target;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      q_push         = 1'b0;
      imem_req_valid = 1'b0;
      if_flush       = redirect & ~rst;
      case (state_q)
         S_REQ: begin
            // In S_REQ the queue always has room for the reply once count < DEPTH.
            imem_req_valid = ~rst & (q_count != FULL);
            // A request accepted alongside a redirect fetches the old address.
            if (imem_req_valid && imem_req_ready)
               state_d = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (redirect) begin
               // A reply landing in the redirect cycle is stale; otherwise wait to drop it.
               state_d = imem_resp_valid ? S_REQ : S_DROP;
            end else if (imem_resp_valid) begin
               q_push     = 1'b1;
               fetch_pc_d = fetch_pc_q + XLEN'(4);
               state_d    = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_resp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      if (redirect) fetch_pc_d = target;
   end

   assign q_in  = '{pc: fetch_pc_q, inst: imem_resp_data};
   assign q_pop = id_valid & id_ready & ~stall & ~redirect;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (q_push),
      .dat_i   (q_in),
      .pop_i   (q_pop),
      .clear_i (redirect),
      .head_o  (q_head),
      .count_o (q_count)
   );

   assign q_empty       = (q_count == '0);
   assign imem_req_addr = fetch_pc_q;
   assign id_valid      = ~q_empty;
   assign id_inst       = q_empty ? NOP_INST : q_head.inst;
   assign id_pc         = q_empty ? '0 : q_head.pc;
   assign id_pc_plus4   = q_empty ? '0 : q_head.pc + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q  <= '0;
         fetched_q <= '0;
         stalls_q  <= '0;
      end else begin
         cycles_q <= cycles_q + CNT_W'(1);
         if (q_pop) fetched_q <= fetched_q + CNT_W'(1);
         if (stall) stalls_q  <= stalls_q + CNT_W'(1);
      end
   end

   assign perf_cycles  = cycles_q;
   assign perf_fetched = fetched_q;
   assign perf_stalls  = stalls_q;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: hand-computed request addresses, ID heads and counters.
// Latency: outputs are snapshotted on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: an optional 1-cycle auto-responder answers every accepted request with 0xA000_0000|addr.
module tb_if_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst, jump, branch, stall, id_ready;
   logic        imem_req_ready, imem_resp_valid;
   logic [31:0] jump_target, branch_target, imem_resp_data;
   logic        imem_req_valid, id_valid, if_flush;
   logic [31:0] imem_req_addr, id_inst, id_pc, id_pc_plus4;
   logic [31:0] perf_cycles, perf_fetched, perf_stalls;

   int n_cmp = 0;
   int n_err = 0;
   int flush_cnt = 0;
   bit resp_en = 1'b1;

   logic        s_req_valid, s_id_valid, s_flush;
   logic [31:0] s_addr, s_id_pc, s_id_inst, s_id_pc4, s_cyc, s_fet, s_stl;
   logic [31:0] req_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_inst_log[$];

   if_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .jump            (jump),
      .jump_target     (jump_target),
      .branch          (branch),
      .branch_target   (branch_target),
      .stall           (stall),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_inst         (id_inst),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .id_ready        (id_ready),
      .if_flush        (if_flush),
      .perf_cycles     (perf_cycles),
      .perf_fetched    (perf_fetched),
      .perf_stalls     (perf_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: snapshot outputs mid-cycle, log handshakes, then drive the responder.
   task automatic tick();
      bit          acc;
      logic [31:0] a;
      @(negedge clk);
      s_req_valid = imem_req_valid;  s_addr   = imem_req_addr;  s_flush = if_flush;
      s_id_valid  = id_valid;        s_id_pc  = id_pc;          s_id_inst = id_inst;
      s_id_pc4    = id_pc_plus4;     s_cyc    = perf_cycles;
      s_fet       = perf_fetched;    s_stl    = perf_stalls;
      acc = imem_req_valid & imem_req_ready;
      a   = imem_req_addr;
      if (acc) req_log.push_back(a);
      if (id_valid & id_ready & ~stall & ~(jump | branch) & ~rst) begin
         pop_pc_log.push_back(id_pc);
         pop_inst_log.push_back(id_inst);
      end
      if (if_flush) flush_cnt++;
      @(posedge clk);
      #1;
      if (resp_en) begin
         imem_resp_valid = acc;
         imem_resp_data  = 32'hA000_0000 | a;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      req_log.delete();
      pop_pc_log.delete();
      pop_inst_log.delete();
      flush_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; jump = 1'b0; branch = 1'b0; stall = 1'b0; id_ready = 1'b0;
      imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      jump_target = '0; branch_target = '0;

      // Reset state, observed in the second reset cycle.
      do_reset();
      chk("rst_req_valid", 32'(s_req_valid), 32'd0);
      chk("rst_req_addr",  s_addr,           32'h0);
      chk("rst_id_valid",  32'(s_id_valid),  32'd0);
      chk("rst_id_inst",   s_id_inst,        32'h0000_0013);
      chk("rst_flush",     32'(s_flush),     32'd0);
      chk("rst_cycles",    s_cyc,            32'd0);

      // 1: streaming fetch with a ready ID stage.
      id_ready = 1'b1;
      repeat (7) tick();
      chk("t1_nreq_ge3",   32'(req_log.size() >= 3),    32'd1);
      chk("t1_req0",       req_log[0],                  32'h0);
      chk("t1_req1",       req_log[1],                  32'h4);
      chk("t1_req2",       req_log[2],                  32'h8);
      chk("t1_npop_ge3",   32'(pop_pc_log.size() >= 3), 32'd1);
      chk("t1_pop_pc0",    pop_pc_log[0],               32'h0);
      chk("t1_pop_pc1",    pop_pc_log[1],               32'h4);
      chk("t1_pop_pc2",    pop_pc_log[2],               32'h8);
      chk("t1_pop_inst1",  pop_inst_log[1],             32'hA000_0004);
      chk("t1_pc_plus4",   s_id_pc4,                    32'hC);
      chk("t1_no_flush",   32'(flush_cnt),              32'd0);

      // 2: ID blocked -> exactly DEPTH requests, then one pop reopens fetch.
      id_ready = 1'b0;
      do_reset();
      repeat (20) tick();
      chk("t2_nreq",       32'(req_log.size()), 32'd4);
      chk("t2_full_noreq", 32'(s_req_valid),    32'd0);
      chk("t2_head_pc",    s_id_pc,             32'h0);
      id_ready = 1'b1;
      tick();
      chk("t2_pop_noreq",  32'(s_req_valid),    32'd0);
      id_ready = 1'b0;
      tick();
      chk("t2_newreq_vld", 32'(s_req_valid),    32'd1);
      chk("t2_newreq_adr", s_addr,              32'h10);
      chk("t2_fetched",    s_fet,               32'd1);

      // 5: stall holds the head for 5 cycles.
      pop_pc_log.delete();
      stall = 1'b1;
      id_ready = 1'b1;
      repeat (5) tick();
      chk("t5_head_held",  s_id_pc,                 32'h4);
      chk("t5_id_valid",   32'(s_id_valid),         32'd1);
      stall = 1'b0;
      id_ready = 1'b0;
      tick();
      chk("t5_stalls",     s_stl,                   32'd5);
      chk("t5_fetched",    s_fet,                   32'd1);
      chk("t5_no_pops",    32'(pop_pc_log.size()),  32'd0);

      // 6: reset while waiting on a response with the queue at capacity.
      resp_en = 1'b0;
      imem_resp_valid = 1'b0;
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      tick();
      chk("t6_req_vld",    32'(s_req_valid), 32'd1);
      chk("t6_req_adr",    s_addr,           32'h14);
      tick();
      chk("t6_wait_noreq", 32'(s_req_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("t6_id_valid",   32'(s_id_valid),  32'd0);
      chk("t6_id_inst",    s_id_inst,        32'h0000_0013);
      chk("t6_addr",       s_addr,           32'h0);
      chk("t6_req_vld2",   32'(s_req_valid), 32'd1);
      chk("t6_cycles",     s_cyc,            32'd0);
      chk("t6_fetched",    s_fet,            32'd0);
      chk("t6_stalls",     s_stl,            32'd0);

      // 3: branch while a request to 0x0 is outstanding.
      flush_cnt = 0;
      branch = 1'b1;
      branch_target = 32'h100;
      tick();
      chk("t3_flush",      32'(s_flush),     32'd1);
      branch = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      chk("t3_flush_off",  32'(s_flush),     32'd0);
      chk("t3_drop_noreq", 32'(s_req_valid), 32'd0);
      imem_resp_valid = 1'b0;
      tick();
      chk("t3_req_vld",    32'(s_req_valid), 32'd1);
      chk("t3_req_adr",    s_addr,           32'h100);
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1234_5678;
      tick();
      imem_resp_valid = 1'b0;
      tick();
      chk("t3_id_valid",   32'(s_id_valid),  32'd1);
      chk("t3_id_pc",      s_id_pc,          32'h100);
      chk("t3_id_inst",    s_id_inst,        32'h1234_5678);
      chk("t3_id_pc4",     s_id_pc4,         32'h104);
      chk("t3_flush_cnt",  32'(flush_cnt),   32'd1);

      // 4: jump and branch together -> jump target wins; queue is cleared.
      jump = 1'b1;
      jump_target = 32'h200;
      branch = 1'b1;
      branch_target = 32'h300;
      tick();
      chk("t4_flush",      32'(s_flush),     32'd1);
      jump = 1'b0;
      branch = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0000;
      tick();
      chk("t4_q_cleared",  32'(s_id_valid),  32'd0);
      imem_resp_valid = 1'b0;
      tick();
      chk("t4_req_vld",    32'(s_req_valid), 32'd1);
      chk("t4_req_adr",    s_addr,           32'h200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
